// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: packs a big-endian word stream into 512-bit chunks,
// appends the 0x80 marker, zero fill and 64-bit bit length, and sequences the core.
module sha1_msg_padder #(
  parameter int MAX_LEN_BITS = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic [2:0]   in_nbytes,
  output logic         in_ready,
  output logic         core_init,
  output logic         core_next,
  output logic [511:0] core_chunk,
  input  logic         core_ready,
  input  logic [159:0] core_digest,
  output logic [159:0] digest,
  output logic         digest_valid,
  output logic         busy
);

  localparam int CNT_W = MAX_LEN_BITS - 3;

  typedef enum logic [2:0] {
    FILL,
    PAD,
    LEN,
    ISSUE,
    HOLD,
    WAIT
  } state_t;

  state_t                  state;
  logic [0:15][31:0]       chunk_q;
  logic [4:0]              word_idx;
  logic [CNT_W-1:0]        byte_cnt;
  logic                    first;
  logic                    is_final;
  logic                    pad_pending;
  logic                    padding;
  logic [2:0]              n_eff;
  logic [31:0]             last_word;
  logic [MAX_LEN_BITS-1:0] bitlen;

  assign in_ready   = (state == FILL) && !reset;
  assign core_chunk = chunk_q;
  assign n_eff      = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
  assign bitlen     = {byte_cnt, 3'b000};

  // Keep the valid leading bytes of the final word and drop the marker right after them.
  always_comb begin
    // NOTE: combinational outputs get a default first so no path can infer a latch.
    last_word = '0;
    case (n_eff)
      3'd0:    last_word = 32'h8000_0000;
      3'd1:    last_word = {in_data[31:24], 24'h80_0000};
      3'd2:    last_word = {in_data[31:16], 16'h8000};
      3'd3:    last_word = {in_data[31:8], 8'h80};
      default: last_word = in_data;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments; pulses default low each cycle.
    core_init    <= 1'b0;
    core_next    <= 1'b0;
    digest_valid <= 1'b0;
    if (reset) begin
      // NOTE: the chunk buffer is reset because it drives core_chunk and doubles as zero fill.
      chunk_q     <= '0;
      state       <= FILL;
      word_idx    <= '0;
      byte_cnt    <= '0;
      first       <= 1'b1;
      is_final    <= 1'b0;
      pad_pending <= 1'b0;
      padding     <= 1'b0;
      digest      <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            busy <= 1'b1;
            if (in_last) begin
              chunk_q[word_idx[3:0]] <= last_word;
              pad_pending            <= (n_eff == 3'd4);
              byte_cnt               <= byte_cnt + CNT_W'(n_eff);
              word_idx               <= word_idx + 5'd1;
              padding                <= 1'b1;
              state                  <= PAD;
            end else begin
              chunk_q[word_idx[3:0]] <= in_data;
              byte_cnt               <= byte_cnt + CNT_W'(4);
              word_idx               <= word_idx + 5'd1;
              if (word_idx == 5'd15) begin
                is_final <= 1'b0;
                state    <= ISSUE;
              end
            end
          end
        end

        // Words 14/15 may still need the marker or zero fill; only a clean
        // word 14 leaves room for the length in this chunk.
        PAD: begin
          if (word_idx == 5'd16) begin
            is_final <= 1'b0;
            state    <= ISSUE;
          end else if (word_idx != 5'd14 || pad_pending) begin
            chunk_q[word_idx[3:0]] <= pad_pending ? 32'h8000_0000 : 32'h0;
            pad_pending            <= 1'b0;
            word_idx               <= word_idx + 5'd1;
          end else begin
            state <= LEN;
          end
        end

        LEN: begin
          chunk_q[14] <= bitlen[63:32];
          chunk_q[15] <= bitlen[31:0];
          is_final    <= 1'b1;
          state       <= ISSUE;
        end

        ISSUE: begin
          if (core_ready) begin
            if (first) core_init <= 1'b1;
            else       core_next <= 1'b1;
            first    <= 1'b0;
            word_idx <= '0;
            state    <= HOLD;
          end
        end

        // The core only drops ready one cycle after the strobe.
        HOLD: state <= WAIT;

        WAIT: begin
          if (core_ready) begin
            chunk_q <= '0;
            if (is_final) begin
              digest       <= core_digest;
              digest_valid <= 1'b1;
              busy         <= 1'b0;
              byte_cnt     <= '0;
              is_final     <= 1'b0;
              first        <= 1'b1;
              padding      <= 1'b0;
              state        <= FILL;
            end else begin
              state <= padding ? PAD : FILL;
            end
          end
        end

        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Bench for sha1_msg_padder: behavioural SHA-1 core plus scoreboards of
// expected chunks and digests, driven by a directed sequence of messages.
module tb_sha1_msg_padder;

  localparam logic [159:0] IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
  localparam logic [159:0] DIG_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] DIG_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
  localparam logic [159:0] DIG_56    = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_last;
  logic [2:0]   in_nbytes;
  logic         in_ready;
  logic         core_init;
  logic         core_next;
  logic [511:0] core_chunk;
  logic         core_ready;
  logic [159:0] core_digest = '0;
  logic [159:0] digest;
  logic         digest_valid;
  logic         busy;

  sha1_msg_padder dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_nbytes    (in_nbytes),
    .in_ready     (in_ready),
    .core_init    (core_init),
    .core_next    (core_next),
    .core_chunk   (core_chunk),
    .core_ready   (core_ready),
    .core_digest  (core_digest),
    .digest       (digest),
    .digest_valid (digest_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] sha1_compress(input logic [159:0] h, input logic [511:0] blk);
    logic [31:0] w [0:79];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      t    = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    {a, b, c, d, e} = h;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);           k = 32'h5a827999; end
      else if (i < 40) begin f = b ^ c ^ d;                    k = 32'h6ed9eba1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d);  k = 32'h8f1bbcdc; end
      else             begin f = b ^ c ^ d;                    k = 32'hca62c1d6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d;
      d = c;
      c = {b[1:0], b[31:2]};
      b = a;
      a = t;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  // Behavioural core: ready drops the cycle after a strobe, digest appears after a fixed latency.
  logic         m_ready = 1'b1;
  logic         block   = 1'b0;
  int           lat_cnt = 0;
  logic [159:0] h_state = '0;

  assign core_ready = m_ready && !block;

  always @(posedge clk) begin
    if (reset) begin
      m_ready <= 1'b1;
      lat_cnt <= 0;
    end else if (core_init || core_next) begin
      h_state <= sha1_compress(core_init ? IV : h_state, core_chunk);
      m_ready <= 1'b0;
      lat_cnt <= 6;
    end else if (lat_cnt > 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1) begin
        m_ready     <= 1'b1;
        core_digest <= h_state;
      end
    end
  end

  typedef struct {
    logic         is_init;
    logic [511:0] chunk;
  } chunk_exp_t;

  chunk_exp_t   chunk_sb[$];
  logic [159:0] dig_sb[$];
  int           strobes_seen = 0;
  int           dv_seen      = 0;

  always @(negedge clk) begin
    chunk_exp_t ce;
    if (!reset && (core_init || core_next)) begin
      strobes_seen++;
      check("chunk_expected", chunk_sb.size() > 0, 1'b1);
      if (chunk_sb.size() > 0) begin
        ce = chunk_sb.pop_front();
        check("strobe_kind", core_init, ce.is_init);
        check("strobe_excl", core_init & core_next, 1'b0);
        check("chunk", core_chunk, ce.chunk);
      end
    end
    if (digest_valid) begin
      dv_seen++;
      check("dv_no_strobe", core_init | core_next, 1'b0);
      check("digest_expected", dig_sb.size() > 0, 1'b1);
      if (dig_sb.size() > 0) check("digest", digest, dig_sb.pop_front());
    end
  end

  task automatic push_chunk(input logic is_init, input logic [511:0] c);
    chunk_exp_t ce;
    ce.is_init = is_init;
    ce.chunk   = c;
    chunk_sb.push_back(ce);
  endtask

  // Called at a negedge; returns at the negedge after the word was accepted.
  task automatic send(input logic [31:0] d, input logic last, input logic [2:0] nb);
    bit ok = 1'b0;
    in_data   = d;
    in_last   = last;
    in_nbytes = nb;
    in_valid  = 1'b1;
    for (int t = 0; t < 500 && !ok; t++) begin
      if (in_ready) begin
        ok = 1'b1;
        @(posedge clk);
      end
      @(negedge clk);
    end
    if (!ok) check("send_accept", ok, 1'b1);
    if (last) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_digest(input int target);
    for (int t = 0; t < 1000 && dv_seen < target; t++) @(negedge clk);
    check("digest_count", dv_seen, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] c1, c2;
    logic [159:0] dexp;

    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_nbytes = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_digest", digest, '0);
    check("rst_dv", digest_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_strobes", {core_init, core_next}, 2'b00);
    check("rst_chunk", core_chunk, '0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1'b1);

    // "abc"
    c1 = '0; c1[511:480] = 32'h61626380; c1[31:0] = 32'h18;
    push_chunk(1'b1, c1);
    dig_sb.push_back(DIG_ABC);
    send(32'h61626300, 1'b1, 3'd3);
    check("busy_abc", busy, 1'b1);
    wait_digest(1);
    check("busy_after_abc", busy, 1'b0);

    // Empty message
    c1 = '0; c1[511:480] = 32'h80000000;
    push_chunk(1'b1, c1);
    dig_sb.push_back(DIG_EMPTY);
    send(32'hffffffff, 1'b1, 3'd0);
    wait_digest(2);
    repeat (5) @(negedge clk);
    check("digest_held", digest, {352'b0, DIG_EMPTY});

    // 56-byte "abcdbcde...nopq": marker lands in word 14, length spills to a second chunk
    c1 = '0;
    for (int i = 0; i < 14; i++)
      c1[511-32*i -: 32] = {8'h61 + 8'(i), 8'h62 + 8'(i), 8'h63 + 8'(i), 8'h64 + 8'(i)};
    c1[511-32*14 -: 32] = 32'h80000000;
    c2 = '0; c2[31:0] = 32'h1c0;
    push_chunk(1'b1, c1);
    push_chunk(1'b0, c2);
    dig_sb.push_back(DIG_56);
    for (int i = 0; i < 14; i++)
      send({8'h61 + 8'(i), 8'h62 + 8'(i), 8'h63 + 8'(i), 8'h64 + 8'(i)}, i == 13, 3'd4);
    wait_digest(3);

    // 64 zero bytes: ends on a chunk boundary
    c1 = '0;
    c2 = '0; c2[511:480] = 32'h80000000; c2[31:0] = 32'h200;
    push_chunk(1'b1, c1);
    push_chunk(1'b0, c2);
    dexp = sha1_compress(sha1_compress(IV, c1), c2);
    dig_sb.push_back(dexp);
    for (int i = 0; i < 16; i++) send(32'h0, i == 15, 3'd4);
    wait_digest(4);
    repeat (10) @(negedge clk);
    check("single_dv_64", dv_seen, 4);

    // Core stalled in ISSUE with the source still offering a word
    c1 = '0;
    for (int i = 0; i < 16; i++) c1[511-32*i -: 32] = 32'h1000_0000 + 32'(i);
    c2 = '0; c2[511:480] = 32'haabb8000; c2[31:0] = 32'h210;
    push_chunk(1'b1, c1);
    push_chunk(1'b0, c2);
    dexp = sha1_compress(sha1_compress(IV, c1), c2);
    dig_sb.push_back(dexp);
    block = 1'b1;
    for (int i = 0; i < 16; i++) send(32'h1000_0000 + 32'(i), 1'b0, 3'd4);
    in_data = 32'haabbccdd; in_last = 1'b1; in_nbytes = 3'd2; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_strobes", strobes_seen, 6);
      check("stall_chunk", core_chunk, c1);
      @(negedge clk);
    end
    block = 1'b0;
    send(32'haabbccdd, 1'b1, 3'd2);
    wait_digest(5);

    // Reset mid-chunk, then "abc" must start fresh with core_init
    for (int i = 0; i < 7; i++) send(32'hdead_0000 + 32'(i), 1'b0, 3'd4);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("midrst_in_ready", in_ready, 1'b0);
    end
    check("midrst_busy", busy, 1'b0);
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    c1 = '0; c1[511:480] = 32'h61626380; c1[31:0] = 32'h18;
    push_chunk(1'b1, c1);
    dig_sb.push_back(DIG_ABC);
    send(32'h61626300, 1'b1, 3'd3);
    wait_digest(6);

    repeat (10) @(negedge clk);
    check("chunks_left", chunk_sb.size(), 0);
    check("digests_left", dig_sb.size(), 0);
    check("strobe_total", strobes_seen, 9);
    check("dv_total", dv_seen, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
